// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle execute.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_AW    = 4,
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch_taken,
   input  logic              ex_mc_start,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_write,
   output logic              idex_flush,
   output logic              exmem_bubble,
   output logic              mc_busy,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MC_BUSY = 1'b1;

   // Counter reload leaves the start cycle and the release cycle outside the countdown.
   localparam logic [3:0] MC_RELOAD = (MC_CYCLES > 1) ? 4'(MC_CYCLES - 2) : 4'd0;

   logic [0:0] state_q, state_d;
   logic [3:0] mc_cnt_q, mc_cnt_d;
   logic       load_use;
   logic       flush_evt;

   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
   end

   always_comb begin
      state_d      = state_q;
      mc_cnt_d     = mc_cnt_q;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_bubble = 1'b0;
      mc_busy      = 1'b0;
      flush_evt    = 1'b0;

      if (!reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         exmem_bubble = 1'b1;
         state_d      = RUN;
         mc_cnt_d     = 4'd0;
      end else if (state_q == RUN) begin
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
         end else if (ex_mc_start && (MC_CYCLES > 1)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mc_busy      = 1'b1;
            state_d      = MC_BUSY;
            mc_cnt_d     = MC_RELOAD;
         end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
         end
      end else begin
         // Frozen ID/EX still presents the mc op; everything is ignored until release.
         if (mc_cnt_q != 4'd0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mc_busy      = 1'b1;
            mc_cnt_d     = mc_cnt_q - 4'd1;
         end else begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RUN;
         mc_cnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   logic unused_flush_evt;
   assign unused_flush_evt = flush_evt;
   assign stall_count      = '0;
   assign flush_count      = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MC_CYCLES=4.
module tb_pipeline_hazard_ctrl;
   localparam int REG_AW    = 4;
   localparam int MC_CYCLES = 4;
   localparam int CNT_W     = 16;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mc_busy}
   localparam logic [6:0] E_DEF = 7'b1101000;
   localparam logic [6:0] E_RST = 7'b0010110;
   localparam logic [6:0] E_BR  = 7'b1111100;
   localparam logic [6:0] E_MCS = 7'b0000011;
   localparam logic [6:0] E_LU  = 7'b0001100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_mc_start;
   logic              pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mc_busy;
   logic [CNT_W-1:0]  stall_count, flush_count;
   logic [6:0]        obs;

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .ex_mc_start(ex_mc_start),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
      .mc_busy(mc_busy), .stall_count(stall_count), .flush_count(flush_count)
   );

   assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mc_busy};

   logic [6:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         vec_no = 0;

   task automatic cyc(input logic rst, input logic br, input logic mc, input logic mr,
                      input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                      input logic [REG_AW-1:0] rs2, input logic u1, input logic u2,
                      input logic [6:0] e);
      @(posedge clk);
      #1;
      reset           = rst;
      ex_branch_taken = br;
      ex_mc_start     = mc;
      ex_mem_read     = mr;
      ex_rd           = rd;
      id_rs1          = rs1;
      id_rs2          = rs2;
      id_rs1_used     = u1;
      id_rs2_used     = u2;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [6:0] e);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, e);
   endtask

   task automatic mc_cyc(input logic br, input logic [6:0] e);
      cyc(1'b1, br, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, e);
   endtask

   // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
   initial begin
      logic [6:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL vec%0d outputs actual=%b required=%b", vec_no, obs, e);
            end
            vec_no++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [CNT_W-1:0] exp_stall, exp_flush;
      int               wait_cyc;
      reset = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0; ex_mem_read = 1'b0;
      ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;

      // Reset held for 3 cycles with active inputs that must be overridden.
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, E_RST);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, E_RST);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, E_RST);
      idle(E_DEF);

      // Load-use on rs2, then r0 never hazards, then rs1 match with and without use.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 4'd5, 1'b0, 1'b1, E_LU);
      idle(E_DEF);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, E_DEF);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 4'd2, 1'b1, 1'b0, E_LU);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 4'd2, 1'b0, 1'b0, E_DEF);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 4'd7, 1'b1, 1'b1, E_DEF);

      // Branch outranks multi-cycle start and load-use; state must stay RUN.
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, E_BR);
      idle(E_DEF);

      // Multi-cycle op held high: 3 stall cycles, release in cycle 4, inputs ignored while busy.
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b1, E_MCS);
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b1, E_DEF);
      // Back-to-back op starts fresh, then reset aborts it in MC_BUSY.
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b0, E_MCS);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, E_RST);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, E_RST);
      idle(E_DEF);
      idle(E_DEF);

      // Counter scenario: 1 load-use stall, one 4-cycle op, 2 branches.
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 4'd0, 1'b1, 1'b0, E_LU);
      idle(E_DEF);
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b0, E_MCS);
      mc_cyc(1'b0, E_DEF);
      idle(E_DEF);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, E_BR);
      idle(E_DEF);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 4'd0, 1'b1, 1'b0, E_BR);
      idle(E_DEF);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end

`ifdef HAZARD_PERF_CNT_EN
      exp_stall = 16'd4;
      exp_flush = 16'd2;
`else
      exp_stall = 16'd0;
      exp_flush = 16'd0;
`endif
      checks++;
      if (stall_count !== exp_stall) begin
         errors++;
         $display("FAIL stall_count actual=%0d required=%0d", stall_count, exp_stall);
      end
      checks++;
      if (flush_count !== exp_flush) begin
         errors++;
         $display("FAIL flush_count actual=%0d required=%0d", flush_count, exp_flush);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage, 16-bit-instruction pipeline. It drives the write-enables and flush controls of the PC and the IF/ID, ID/EX and EX/MEM buffers.
- Resolves three events:
  - load-use hazards detected in decode;
  - taken branches resolved in execute;
  - multi-cycle ALU ops (mul/div) that hold the execute stage for several cycles.
- Sits beside the hazard and branch-control logic in the top-level cpu.

Parameters:
- REG_AW, 4, register-address width (16 architectural registers; r0 is hardwired zero).
- MC_CYCLES, 4, execute-stage occupancy of a multi-cycle op in cycles. Legal range 1..16; 1 means no stall.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_AW  source register 1 of the instruction in decode.
- id_rs2  in  REG_AW  source register 2 of the instruction in decode.
- id_rs1_used  in  1  decode instruction reads rs1.
- id_rs2_used  in  1  decode instruction reads rs2.
- ex_mem_read  in  1  instruction in execute is a load.
- ex_rd  in  REG_AW  destination register of the instruction in execute.
- ex_branch_taken  in  1  branch in execute resolved taken this cycle.
- ex_mc_start  in  1  instruction in execute is a multi-cycle op.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID buffer load enable.
- ifid_flush  out  1  IF/ID buffer loads a NOP.
- idex_write  out  1  ID/EX buffer load enable.
- idex_flush  out  1  ID/EX buffer loads a bubble (all control bits 0).
- exmem_bubble  out  1  EX/MEM buffer loads a bubble instead of the ALU result.
- mc_busy  out  1  high while a multi-cycle op is in progress.
- stall_count  out  CNT_W  stall-cycle counter. Present only with the optional feature; otherwise tied 0.
- flush_count  out  CNT_W  flush-event counter. Present only with the optional feature; otherwise tied 0.

Behaviour:
- State machine: RUN and MC_BUSY. The down-counter mc_cnt is 4 bits wide.
- Reset (reset=0, asynchronous):
  - state=RUN, mc_cnt=0, counters=0.
  - While reset is low, outputs are forced to: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_flush=1, exmem_bubble=1, mc_busy=0.
- Default in RUN with no event: pc_write=1, ifid_write=1, idex_write=1, all flush/bubble=0.
- Outputs are combinational from state, mc_cnt and the current inputs. All registered state updates on the rising clk edge.
- Priority in RUN, first match wins:
  1. Branch taken:
     - Condition: ex_branch_taken=1.
     - Outputs: ifid_flush=1, idex_flush=1; pc_write, ifid_write, idex_write stay 1.
     - ex_mc_start is ignored in the same cycle. Any concurrent load-use hazard is suppressed, because the decode instruction is flushed.
  2. Multi-cycle start:
     - Condition: ex_mc_start=1 and MC_CYCLES>1.
     - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, mc_busy=1.
     - Next cycle: state=MC_BUSY, mc_cnt=MC_CYCLES-2.
     - With MC_CYCLES=1 there is no action.
  3. Load-use:
     - Condition: ex_mem_read=1, ex_rd!=0, and ((id_rs1_used && id_rs1==ex_rd) or (id_rs2_used && id_rs2==ex_rd)).
     - Outputs: pc_write=0, ifid_write=0, idex_flush=1, for exactly one cycle.
     - No state change is needed; the next cycle sees the bubble in execute.
- MC_BUSY:
  - All inputs are ignored, including the ex_mc_start still held by the frozen ID/EX buffer.
  - When mc_cnt!=0: stall outputs as in the multi-cycle start case; mc_cnt decrements.
  - When mc_cnt==0 (final cycle): mc_busy=0, exmem_bubble=0 so the result enters EX/MEM; enables return to 1; next state=RUN.
  - Total execute occupancy is exactly MC_CYCLES cycles.
- Back-to-back multi-cycle ops: the second op re-enters RUN priority the cycle after release and starts a fresh sequence.
- Reset low mid-MC_BUSY: the sequence is aborted immediately and no result is released.
- Register r0 never produces a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with pc_write=0 while reset is high.
  - flush_count increments on every cycle with a taken-branch flush.
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: the counters are not built and both outputs are constant 0.

Test Plan:
- Reset held low for 3 cycles, then released -> during reset all enables are 0 and flushes/bubble are 1; the first cycle after release shows pc_write=ifid_write=idex_write=1 with flushes 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for one cycle -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; the next cycle is the normal default. Repeat with ex_rd=0 -> no stall.
- ex_mc_start=1, held high, with MC_CYCLES=4 -> mc_busy=1 and exmem_bubble=1 for cycles 1-3; in cycle 4 exmem_bubble=0 and enables are 1; cycle 5 is in RUN.
- ex_branch_taken=1 together with ex_mc_start=1 and a load-use match -> only ifid_flush=idex_flush=1; no stall, and state stays RUN.
- Reset driven low asynchronously mid-edge during MC_BUSY cycle 2 -> outputs go to reset values immediately; after release, state is RUN and mc_busy=0.
- With HAZARD_PERF_CNT_EN defined: 1 load-use stall + one 4-cycle multi-cycle op + 2 branches -> stall_count=4, flush_count=2.
